// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data SRAM access controller.
//   OP_LW / OP_SW : opcodes (IR[31:26]) that need a data-memory access
//   state_t       : transaction sequencer states
//   owner_t       : which requester owns the SRAM for the current transaction
package mips_mem_pkg;

    localparam logic [5:0] OP_LW = 6'b110000;
    localparam logic [5:0] OP_SW = 6'b110001;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic {
        PIPE,
        DBG
    } owner_t;

    // True for the opcodes that must go through the data SRAM.
    function automatic logic is_mem_op(input logic [5:0] opcode);
        return (opcode == OP_LW) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/dmem_starve_guard.sv
// Starvation guard for the debug port.
// Counts consecutive pipeline grants made while a debug request was waiting
// and raises force_dbg once the count reaches STARVE_MAX, so the arbiter
// hands the next transaction to the debug port.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_idle      : arbiter is in its arbitration state this cycle
//   dbg_valid    : debug request pending
//   grant_pipe   : arbiter grants the pipeline this cycle
//   grant_dbg    : arbiter grants the debug port this cycle
//   force_dbg    : debug must win the current arbitration
module dmem_starve_guard #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_idle,
    input  logic dbg_valid,
    input  logic grant_pipe,
    input  logic grant_dbg,
    output logic force_dbg
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    // The count only survives while debug keeps waiting; any debug grant or
    // an idle cycle with no debug request starts the fairness window over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_dbg) begin
            starve_cnt <= '0;
        end else if (in_idle && !dbg_valid) begin
            starve_cnt <= '0;
        end else if (grant_pipe && dbg_valid && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force_dbg = dbg_valid && (starve_cnt == CNT_MAX);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data SRAM sequencer.
// Arbitrates a single-port synchronous SRAM between the pipeline (LW/SW in
// IR_ex) and a debug/loader port, stalls the pipeline until its access
// completes and returns load data on LMD.
//   clk, rst_n                : clock, asynchronous active-low reset
//   IR_ex, ALU_ex, D_ex       : instruction, effective address, store data from EX
//   IR_mem, ALU_mem           : pass-through of IR_ex / ALU_ex
//   LMD                       : load data towards MEM/WB
//   pipe_stall                : hold EX/MEM and earlier stages
//   dbg_valid/ready/we/addr/wdata : debug request handshake and payload
//   dbg_rvalid, dbg_rdata     : debug read response (single-cycle pulse)
//   mem_en/we/addr/wdata      : SRAM request (mem_en one cycle per transaction)
//   mem_rdata                 : SRAM read data, valid RD_LAT cycles after mem_en
module dmem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       IR_ex,
    input  logic [31:0]       ALU_ex,
    input  logic [31:0]       D_ex,
    output logic [31:0]       IR_mem,
    output logic [31:0]       ALU_mem,
    output logic [31:0]       LMD,
    output logic              pipe_stall,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    state_t            state_q;
    state_t            state_d;
    owner_t            owner_q;
    logic              we_q;
    logic [LAT_W-1:0]  busy_cnt;
    logic [31:0]       lmd_q;
    logic [31:0]       dbg_rdata_q;

    logic              pipe_req;
    logic              pipe_is_sw;
    logic              grant_pipe;
    logic              grant_dbg;
    logic              grant_any;
    logic              grant_we;
    logic              busy_last;
    logic              force_dbg;
    logic              resp_read;

    assign IR_mem     = IR_ex;
    assign ALU_mem    = ALU_ex;
    assign pipe_req   = is_mem_op(IR_ex[31:26]);
    assign pipe_is_sw = (IR_ex[31:26] == OP_SW);
    assign busy_last  = (busy_cnt == LAT_LAST);

    dmem_starve_guard #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_guard (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_idle    (state_q == IDLE),
        .dbg_valid  (dbg_valid),
        .grant_pipe (grant_pipe),
        .grant_dbg  (grant_dbg),
        .force_dbg  (force_dbg)
    );

    // Arbitration and next state. A forced debug grant beats the pipeline;
    // otherwise the pipeline has priority. Writes spend one cycle in BUSY,
    // reads stay until the SRAM read latency has elapsed.
    always_comb begin
        state_d    = state_q;
        grant_pipe = 1'b0;
        grant_dbg  = 1'b0;
        case (state_q)
            IDLE: begin
                if (force_dbg) begin
                    grant_dbg = 1'b1;
                end else if (pipe_req) begin
                    grant_pipe = 1'b1;
                end else if (dbg_valid) begin
                    grant_dbg = 1'b1;
                end
                if (grant_pipe || grant_dbg) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (we_q || busy_last) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant_any = grant_pipe || grant_dbg;
    assign grant_we  = grant_dbg ? dbg_we : pipe_is_sw;

    // Transaction registers. Address, data and direction are captured only
    // at the grant, so EX may change them freely while the access is in
    // flight. mem_en/mem_we are high for exactly the first BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= PIPE;
            we_q        <= 1'b0;
            busy_cnt    <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            lmd_q       <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                owner_q   <= grant_dbg ? DBG : PIPE;
                we_q      <= grant_we;
                busy_cnt  <= '0;
                mem_en    <= 1'b1;
                mem_we    <= grant_we;
                mem_addr  <= grant_dbg ? dbg_addr : ALU_ex[ADDR_W-1:0];
                mem_wdata <= grant_dbg ? dbg_wdata : D_ex;
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end
            if (state_q == BUSY) begin
                busy_cnt <= busy_cnt + 1'b1;
            end
            if (resp_read && (owner_q == PIPE)) begin
                lmd_q <= mem_rdata;
            end
            if (resp_read && (owner_q == DBG)) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

    // Read data is forwarded straight from the SRAM in the response cycle so
    // the pipeline can advance in that same cycle; afterwards the held copy
    // is presented.
    assign resp_read  = (state_q == RESP) && !we_q;
    assign LMD        = (resp_read && (owner_q == PIPE)) ? mem_rdata : lmd_q;
    assign dbg_rvalid = resp_read && (owner_q == DBG);
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;
    assign dbg_ready  = grant_dbg;
    assign pipe_stall = pipe_req && !((state_q == RESP) && (owner_q == PIPE));

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl.
// Instance A runs with RD_LAT=1, instance B with RD_LAT=3; each has a
// behavioural SRAM whose read data appears RD_LAT cycles after mem_en.
module tb_dmem_access_ctrl;
    import mips_mem_pkg::*;

    localparam int ADDR_W = 10;

    logic clk;
    logic rst_n;

    // Instance A (RD_LAT = 1)
    logic [31:0]       ir_a, alu_a, d_a;
    logic [31:0]       ir_mem_a, alu_mem_a, lmd_a;
    logic              pipe_stall_a;
    logic              dbg_valid_a, dbg_ready_a, dbg_we_a, dbg_rvalid_a;
    logic [ADDR_W-1:0] dbg_addr_a;
    logic [31:0]       dbg_wdata_a, dbg_rdata_a;
    logic              mem_en_a, mem_we_a;
    logic [ADDR_W-1:0] mem_addr_a;
    logic [31:0]       mem_wdata_a, mem_rdata_a;

    // Instance B (RD_LAT = 3)
    logic [31:0]       ir_b, alu_b, d_b;
    logic [31:0]       ir_mem_b, alu_mem_b, lmd_b;
    logic              pipe_stall_b;
    logic              dbg_ready_b, dbg_rvalid_b;
    logic [31:0]       dbg_rdata_b;
    logic              mem_en_b, mem_we_b;
    logic [ADDR_W-1:0] mem_addr_b;
    logic [31:0]       mem_wdata_b, mem_rdata_b;

    logic [31:0] sram_a [0:(1<<ADDR_W)-1];
    logic [31:0] sram_b [0:(1<<ADDR_W)-1];
    logic [31:0] rd_a;
    logic [31:0] rd_b [0:2];

    int total;
    int bad;
    int en_count_a, we_count_a, en_count_b;

    localparam logic [31:0] LW_INSN  = {OP_LW, 26'd0};
    localparam logic [31:0] SW_INSN  = {OP_SW, 26'd0};
    localparam logic [31:0] ADD_INSN = {6'b000000, 5'd1, 5'd2, 5'd3, 11'h020};
    localparam logic [31:0] NOP_INSN = 32'h0;

    dmem_access_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .IR_ex(ir_a), .ALU_ex(alu_a), .D_ex(d_a),
        .IR_mem(ir_mem_a), .ALU_mem(alu_mem_a), .LMD(lmd_a),
        .pipe_stall(pipe_stall_a),
        .dbg_valid(dbg_valid_a), .dbg_ready(dbg_ready_a), .dbg_we(dbg_we_a),
        .dbg_addr(dbg_addr_a), .dbg_wdata(dbg_wdata_a),
        .dbg_rvalid(dbg_rvalid_a), .dbg_rdata(dbg_rdata_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    dmem_access_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .IR_ex(ir_b), .ALU_ex(alu_b), .D_ex(d_b),
        .IR_mem(ir_mem_b), .ALU_mem(alu_mem_b), .LMD(lmd_b),
        .pipe_stall(pipe_stall_b),
        .dbg_valid(1'b0), .dbg_ready(dbg_ready_b), .dbg_we(1'b0),
        .dbg_addr('0), .dbg_wdata(32'h0),
        .dbg_rvalid(dbg_rvalid_b), .dbg_rdata(dbg_rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    always #5 clk = ~clk;

    // Behavioural SRAMs: array written in place, read data pipelined by RD_LAT.
    always @(posedge clk) begin
        if (mem_en_a) begin
            en_count_a = en_count_a + 1;
            if (mem_we_a) begin
                we_count_a = we_count_a + 1;
                sram_a[mem_addr_a] = mem_wdata_a;
            end else begin
                rd_a <= sram_a[mem_addr_a];
            end
        end
    end
    assign mem_rdata_a = rd_a;

    always @(posedge clk) begin
        if (mem_en_b) begin
            en_count_b = en_count_b + 1;
            if (mem_we_b) begin
                sram_b[mem_addr_b] = mem_wdata_b;
            end else begin
                rd_b[0] <= sram_b[mem_addr_b];
            end
        end
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end
    assign mem_rdata_b = rd_b[2];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] d);
        ir_a  = ir;
        alu_a = alu;
        d_a   = d;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        int we_base;
        int en_base;
        int stall_count;
        logic done;

        clk = 1'b0;
        rst_n = 1'b0;
        total = 0;
        bad = 0;
        en_count_a = 0;
        we_count_a = 0;
        en_count_b = 0;
        ir_a = NOP_INSN; alu_a = '0; d_a = '0;
        ir_b = NOP_INSN; alu_b = '0; d_b = '0;
        dbg_valid_a = 1'b0; dbg_we_a = 1'b0; dbg_addr_a = '0; dbg_wdata_a = '0;
        sram_a[5] = 32'hDEADBEEF;
        sram_b[9] = 32'hCAFEF00D;

        $display("[TB] reset");
        repeat (2) tick();
        checkOutput("rst_mem_en", {31'd0, mem_en_a}, 32'd0);
        checkOutput("rst_mem_addr", {22'd0, mem_addr_a}, 32'd0);
        checkOutput("rst_lmd", lmd_a, 32'd0);
        checkOutput("rst_dbg_ready", {31'd0, dbg_ready_a}, 32'd0);
        checkOutput("rst_dbg_rvalid", {31'd0, dbg_rvalid_a}, 32'd0);
        checkOutput("rst_dbg_rdata", dbg_rdata_a, 32'd0);
        checkOutput("rst_stall", {31'd0, pipe_stall_a}, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] LW addr 5");
        applyStimulus(LW_INSN, 32'hFFFF_F005, 32'h0);
        checkOutput("lw_t0_stall", {31'd0, pipe_stall_a}, 32'd1);
        checkOutput("lw_t0_en", {31'd0, mem_en_a}, 32'd0);
        checkOutput("ir_pass", ir_mem_a, LW_INSN);
        checkOutput("alu_pass", alu_mem_a, 32'hFFFF_F005);
        tick();
        checkOutput("lw_t1_en", {31'd0, mem_en_a}, 32'd1);
        checkOutput("lw_t1_we", {31'd0, mem_we_a}, 32'd0);
        checkOutput("lw_t1_addr", {22'd0, mem_addr_a}, 32'd5);
        checkOutput("lw_t1_stall", {31'd0, pipe_stall_a}, 32'd1);
        tick();
        checkOutput("lw_t2_stall", {31'd0, pipe_stall_a}, 32'd0);
        checkOutput("lw_t2_lmd", lmd_a, 32'hDEADBEEF);
        checkOutput("lw_t2_en", {31'd0, mem_en_a}, 32'd0);

        $display("[TB] SW addr 7 then LW addr 7");
        we_base = we_count_a;
        applyStimulus(SW_INSN, 32'h7, 32'h12345678);
        tick();
        checkOutput("sw_t0_stall", {31'd0, pipe_stall_a}, 32'd1);
        checkOutput("sw_t0_lmd_hold", lmd_a, 32'hDEADBEEF);
        tick();
        checkOutput("sw_t1_en", {31'd0, mem_en_a}, 32'd1);
        checkOutput("sw_t1_we", {31'd0, mem_we_a}, 32'd1);
        checkOutput("sw_t1_addr", {22'd0, mem_addr_a}, 32'd7);
        checkOutput("sw_t1_wdata", mem_wdata_a, 32'h12345678);
        tick();
        checkOutput("sw_t2_stall", {31'd0, pipe_stall_a}, 32'd0);
        applyStimulus(LW_INSN, 32'h7, 32'h0);
        tick();
        tick();
        checkOutput("lw7_t1_en", {31'd0, mem_en_a}, 32'd1);
        checkOutput("lw7_t1_we", {31'd0, mem_we_a}, 32'd0);
        tick();
        checkOutput("lw7_lmd", lmd_a, 32'h12345678);
        checkOutput("sw_single_we", we_count_a - we_base, 32'd1);

        $display("[TB] ADD opcode, no access");
        en_base = en_count_a;
        applyStimulus(ADD_INSN, 32'h7, 32'hFFFFFFFF);
        checkOutput("add_stall_resp", {31'd0, pipe_stall_a}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("add_stall", {31'd0, pipe_stall_a}, 32'd0);
            checkOutput("add_lmd_hold", lmd_a, 32'h12345678);
        end
        checkOutput("add_no_en", en_count_a - en_base, 32'd0);

        $display("[TB] LW stream with debug read pending");
        dbg_valid_a = 1'b1;
        dbg_we_a    = 1'b0;
        dbg_addr_a  = 10'd7;
        dbg_wdata_a = 32'hA5A5A5A5;
        applyStimulus(LW_INSN, 32'h5, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("starve_dbg_ready", {31'd0, dbg_ready_a}, 32'd0);
            checkOutput("starve_stall", {31'd0, pipe_stall_a}, 32'd1);
            tick();
            checkOutput("starve_pipe_addr", {21'd0, mem_en_a, mem_addr_a}, {21'd0, 1'b1, 10'd5});
            tick();
            checkOutput("starve_lmd", lmd_a, 32'hDEADBEEF);
            tick();
        end
        checkOutput("force_dbg_ready", {31'd0, dbg_ready_a}, 32'd1);
        checkOutput("force_stall", {31'd0, pipe_stall_a}, 32'd1);
        tick();
        dbg_valid_a = 1'b0;
        checkOutput("dbg_t1_addr", {21'd0, mem_en_a, mem_addr_a}, {21'd0, 1'b1, 10'd7});
        checkOutput("dbg_t1_we", {31'd0, mem_we_a}, 32'd0);
        tick();
        checkOutput("dbg_rvalid", {31'd0, dbg_rvalid_a}, 32'd1);
        checkOutput("dbg_rdata", dbg_rdata_a, 32'h12345678);
        checkOutput("dbg_resp_stall", {31'd0, pipe_stall_a}, 32'd1);
        checkOutput("dbg_resp_lmd", lmd_a, 32'hDEADBEEF);
        tick();
        checkOutput("dbg_rvalid_pulse", {31'd0, dbg_rvalid_a}, 32'd0);
        checkOutput("after_dbg_ready", {31'd0, dbg_ready_a}, 32'd0);
        checkOutput("after_dbg_stall", {31'd0, pipe_stall_a}, 32'd1);

        $display("[TB] reset during BUSY");
        tick();
        checkOutput("pre_rst_en", {31'd0, mem_en_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_en", {31'd0, mem_en_a}, 32'd0);
        checkOutput("mid_rst_addr", {22'd0, mem_addr_a}, 32'd0);
        checkOutput("mid_rst_stall", {31'd0, pipe_stall_a}, 32'd1);
        checkOutput("mid_rst_lmd", lmd_a, 32'd0);
        tick();
        checkOutput("held_rst_en", {31'd0, mem_en_a}, 32'd0);
        rst_n = 1'b1;
        #1;
        tick();
        checkOutput("reissue_en", {21'd0, mem_en_a, mem_addr_a}, {21'd0, 1'b1, 10'd5});
        checkOutput("reissue_stall", {31'd0, pipe_stall_a}, 32'd1);
        tick();
        checkOutput("reissue_lmd", lmd_a, 32'hDEADBEEF);
        checkOutput("reissue_stall_rel", {31'd0, pipe_stall_a}, 32'd0);
        applyStimulus(NOP_INSN, 32'h0, 32'h0);

        $display("[TB] RD_LAT=3 LW addr 9");
        en_base = en_count_b;
        ir_b  = LW_INSN;
        alu_b = 32'h9;
        #1;
        stall_count = 0;
        done = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            if (pipe_stall_b) begin
                stall_count++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        checkOutput("lat3_completed", {31'd0, done}, 32'd1);
        checkOutput("lat3_stall_cycles", stall_count, 32'd4);
        checkOutput("lat3_lmd", lmd_b, 32'hCAFEF00D);
        checkOutput("lat3_single_en", en_count_b - en_base, 32'd1);
        ir_b = NOP_INSN;
        tick();
        checkOutput("lat3_lmd_hold", lmd_b, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
